loot_hook_ctrl: RTL and testbench

//  Loot-side partner of the claw mover: consumes claw position, loot hits and

---
 rtl/loot_hook_ctrl.sv | 137 +++++++++++++
 tb/tb_loot_hook_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/loot_hook_ctrl.sv
// Loot-side partner of the claw mover: latches the first live loot hit, sets the
// reel speed by loot type, drags the hooked sprite and credits score on return.
module loot_hook_ctrl #(
  parameter int NUM_LOOT    = 8,
  parameter int EMPTY_SPEED = 4,
  parameter int HOOK_X_OFS  = 0,
  parameter int HOOK_Y_OFS  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_level,
  input  logic [NUM_LOOT-1:0]     level_mask,
  input  logic [2*NUM_LOOT-1:0]   loot_types,
  input  logic [NUM_LOOT-1:0]     loot_hit,
  input  logic                    claw_returned,
  input  logic signed [10:0]      claw_x,
  input  logic signed [10:0]      claw_y,
  output logic [3:0]              move_speed,
  output logic [NUM_LOOT-1:0]     loot_alive,
  output logic                    hooked_valid,
  output logic [3:0]              hooked_idx,
  output logic signed [10:0]      hooked_x,
  output logic signed [10:0]      hooked_y,
  output logic                    score_pulse,
  output logic [9:0]              score_value,
  output logic [15:0]             total_score
);

  // state    | meaning
  // S_EMPTY  | nothing on the hook, waiting for a live hit
  // S_HOOKED | loot attached, sprite follows claw until return
  // S_AWARD  | one-cycle delivery, score already credited
  typedef enum logic [1:0] {S_EMPTY, S_HOOKED, S_AWARD} state_t;

  localparam logic [3:0]         SPEED_IDLE = 4'(EMPTY_SPEED);
  localparam logic signed [10:0] X_OFS      = 11'(HOOK_X_OFS);
  localparam logic signed [10:0] Y_OFS      = 11'(HOOK_Y_OFS);

  state_t              state;
  logic [1:0]          hooked_type;
  logic [NUM_LOOT-1:0] eff_hit;
  logic                hit_found;
  logic [3:0]          hit_idx;
  logic [1:0]          hit_type;
  logic [9:0]          award_value;
  logic [16:0]         score_sum;

  function automatic logic [3:0] speed_of(input logic [1:0] t);
    case (t)
      2'd0:    speed_of = 4'd4;
      2'd1:    speed_of = 4'd1;
      2'd2:    speed_of = 4'd2;
      default: speed_of = 4'd8;
    endcase
  endfunction

  function automatic logic [9:0] value_of(input logic [1:0] t);
    case (t)
      2'd0:    value_of = 10'd50;
      2'd1:    value_of = 10'd250;
      2'd2:    value_of = 10'd20;
      default: value_of = 10'd600;
    endcase
  endfunction

  // Descending scan so the lowest live index is the one left standing.
  always_comb begin
    eff_hit   = loot_hit & loot_alive;
    hit_found = 1'b0;
    hit_idx   = 4'd0;
    hit_type  = 2'd0;
    for (int i = NUM_LOOT - 1; i >= 0; i--) begin
      if (eff_hit[i]) begin
        hit_found = 1'b1;
        hit_idx   = 4'(i);
        hit_type  = loot_types[2*i +: 2];
      end
    end
    award_value = value_of(hooked_type);
    score_sum   = {1'b0, total_score} + 17'(award_value);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_EMPTY;
      move_speed   <= SPEED_IDLE;
      loot_alive   <= '0;
      hooked_valid <= 1'b0;
      hooked_idx   <= 4'd0;
      hooked_type  <= 2'd0;
      hooked_x     <= '0;
      hooked_y     <= '0;
      score_pulse  <= 1'b0;
      score_value  <= 10'd0;
      total_score  <= 16'd0;
    end else if (start_level) begin
      state        <= S_EMPTY;
      loot_alive   <= level_mask;
      hooked_valid <= 1'b0;
      move_speed   <= SPEED_IDLE;
      score_pulse  <= 1'b0;
    end else begin
      score_pulse <= 1'b0;
      case (state)
        S_EMPTY: begin
          // A return in the same cycle as a hit means the claw is already home.
          if (hit_found && !claw_returned) begin
            state        <= S_HOOKED;
            hooked_valid <= 1'b1;
            hooked_idx   <= hit_idx;
            hooked_type  <= hit_type;
            move_speed   <= speed_of(hit_type);
            hooked_x     <= claw_x + X_OFS;
            hooked_y     <= claw_y + Y_OFS;
          end
        end
        S_HOOKED: begin
          hooked_x <= claw_x + X_OFS;
          hooked_y <= claw_y + Y_OFS;
          if (claw_returned) begin
            state        <= S_AWARD;
            score_pulse  <= 1'b1;
            score_value  <= award_value;
            total_score  <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
            hooked_valid <= 1'b0;
            move_speed   <= SPEED_IDLE;
            for (int i = 0; i < NUM_LOOT; i++) begin
              if (hooked_idx == 4'(i)) loot_alive[i] <= 1'b0;
            end
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_loot_hook_ctrl.sv
// Scoreboarded bench for loot_hook_ctrl: expected deliveries are queued when the
// claw is returned and compared when score_pulse fires.
module tb_loot_hook_ctrl;

  logic               clk = 1'b0;
  logic               reset;
  logic               start_level;
  logic [7:0]         level_mask;
  logic [15:0]        loot_types;
  logic [7:0]         loot_hit;
  logic               claw_returned;
  logic signed [10:0] claw_x;
  logic signed [10:0] claw_y;
  logic [3:0]         move_speed;
  logic [7:0]         loot_alive;
  logic               hooked_valid;
  logic [3:0]         hooked_idx;
  logic signed [10:0] hooked_x;
  logic signed [10:0] hooked_y;
  logic               score_pulse;
  logic [9:0]         score_value;
  logic [15:0]        total_score;

  int n_cmp = 0;
  int n_bad = 0;
  logic [25:0] exp_q[$];
  logic [15:0] model_total = 16'd0;

  always #5 clk = ~clk;

  loot_hook_ctrl dut (
    .clk(clk), .reset(reset), .start_level(start_level), .level_mask(level_mask),
    .loot_types(loot_types), .loot_hit(loot_hit), .claw_returned(claw_returned),
    .claw_x(claw_x), .claw_y(claw_y), .move_speed(move_speed), .loot_alive(loot_alive),
    .hooked_valid(hooked_valid), .hooked_idx(hooked_idx), .hooked_x(hooked_x),
    .hooked_y(hooked_y), .score_pulse(score_pulse), .score_value(score_value),
    .total_score(total_score)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && score_pulse) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        chk("score_value", 32'(score_value), 32'(e[25:16]));
        chk("total_score", 32'(total_score), 32'(e[15:0]));
      end
    end
  end

  task automatic new_level(input logic [7:0] mask, input logic [15:0] types);
    level_mask  = mask;
    loot_types  = types;
    start_level = 1'b1;
    tick();
    start_level = 1'b0;
  endtask

  task automatic hook(input logic [7:0] hits);
    loot_hit = hits;
    tick();
    loot_hit = 8'h00;
  endtask

  task automatic give_back(input logic [9:0] value);
    logic [16:0] s;
    s = {1'b0, model_total} + 17'(value);
    model_total = s[16] ? 16'hFFFF : s[15:0];
    exp_q.push_back({value, model_total});
    claw_returned = 1'b1;
    tick();
    claw_returned = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    chk("pulse_timeout", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    reset = 1'b1; start_level = 1'b0; level_mask = 8'h00; loot_types = 16'h0000;
    loot_hit = 8'h00; claw_returned = 1'b0; claw_x = 11'sd0; claw_y = 11'sd0;
    tick(2);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_speed", 32'(move_speed), 32'd4);
    chk("rst_alive", 32'(loot_alive), 32'd0);
    chk("rst_valid", 32'(hooked_valid), 32'd0);
    chk("rst_idx", 32'(hooked_idx), 32'd0);
    chk("rst_xy", 32'({hooked_x, hooked_y}), 32'd0);
    chk("rst_total", 32'(total_score), 32'd0);
    tick();

    // 1: big gold at idx 3
    new_level(8'hFF, 16'h5555);
    chk("t1_alive", 32'(loot_alive), 32'hFF);
    hook(8'h08);
    chk("t1_valid", 32'(hooked_valid), 32'd1);
    chk("t1_idx", 32'(hooked_idx), 32'd3);
    chk("t1_speed", 32'(move_speed), 32'd1);
    give_back(10'd250);
    chk("t1_alive_after", 32'(loot_alive), 32'hF7);
    chk("t1_speed_after", 32'(move_speed), 32'd4);
    chk("t1_valid_after", 32'(hooked_valid), 32'd0);

    // 2: multi-hot, lowest index wins; later hits and type changes ignored
    loot_types = 16'h5565;
    hook(8'b0010_0100);
    chk("t2_idx", 32'(hooked_idx), 32'd2);
    chk("t2_speed", 32'(move_speed), 32'd2);
    loot_types = 16'h5575;
    hook(8'h20);
    chk("t2_idx_hold", 32'(hooked_idx), 32'd2);
    chk("t2_speed_hold", 32'(move_speed), 32'd2);
    give_back(10'd20);
    chk("t2_alive_after", 32'(loot_alive), 32'hF3);

    // 3: dead loot never hooks; empty return scores nothing; return beats hit
    hook(8'h08);
    tick();
    chk("t3_valid", 32'(hooked_valid), 32'd0);
    chk("t3_speed", 32'(move_speed), 32'd4);
    claw_returned = 1'b1;
    loot_hit = 8'h01;
    tick();
    claw_returned = 1'b0;
    loot_hit = 8'h00;
    tick(2);
    chk("t3_ret_hit_valid", 32'(hooked_valid), 32'd0);

    // 4: sprite follows the claw with offset, wrapping at 11 bits
    loot_types = 16'h5555;
    hook(8'h01);
    claw_x = 11'sd100;
    claw_y = -11'sd5;
    tick();
    chk("t4_x", 32'(hooked_x), 32'(11'sd100));
    chk("t4_y", 32'(hooked_y), 32'(11'sd11));
    claw_x = 11'sd1023;
    claw_y = 11'sd1020;
    tick();
    chk("t4_x_max", 32'(hooked_x), 32'(11'sd1023));
    chk("t4_y_wrap", 32'(hooked_y), 32'(-11'sd1012));
    give_back(10'd250);

    // 5: diamonds until the total saturates, then once more
    for (int n = 0; n < 200 && model_total != 16'hFFFF; n++) begin
      new_level(8'hFF, 16'hFFFF);
      hook(8'h80);
      give_back(10'd600);
    end
    chk("t5_sat", 32'(total_score), 32'hFFFF);
    new_level(8'hFF, 16'hFFFF);
    hook(8'h40);
    chk("t5_speed", 32'(move_speed), 32'd8);
    give_back(10'd600);
    chk("t5_sat_hold", 32'(total_score), 32'hFFFF);

    // 6: new level mid-trip abandons the hook without scoring
    hook(8'h01);
    chk("t6_hooked", 32'(hooked_valid), 32'd1);
    new_level(8'h3C, 16'h0000);
    chk("t6_valid", 32'(hooked_valid), 32'd0);
    chk("t6_speed", 32'(move_speed), 32'd4);
    chk("t6_alive", 32'(loot_alive), 32'h3C);
    claw_returned = 1'b1;
    tick();
    claw_returned = 1'b0;
    tick(3);
    chk("t6_total", 32'(total_score), 32'hFFFF);
    hook(8'h05);
    chk("t6_rehook_idx", 32'(hooked_idx), 32'd2);
    chk("t6_rehook_speed", 32'(move_speed), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
